// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Purpose:
//   Multi-cycle control unit that walks each instruction through the
//   FETCH -> DECODE -> EXEC -> MEM -> WB phases. It drives the datapath and
//   memory control strobes for the current phase. It also stalls on the memory
//   ready handshake and flags undefined opcodes.
//
// Ports:
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       synchronous active-low reset
//   en          in   1       1 = advance, 0 = freeze state/opcode_q, outputs 0
//   opcode      in   OPW     opcode field from the instruction register
//   mem_ready   in   1       memory finished the current read/write
//   branch      out  1       branch compare enable
//   regdst      out  1       1 = rd, 0 = rt as write register
//   alusrc      out  1       1 = immediate ALU operand B
//   regwrite    out  1       register file write strobe
//   memread     out  1       memory read request
//   memreg      out  1       1 = writeback from memory, 0 = from ALU
//   memwrite    out  1       memory write request
//   iord        out  1       0 = PC addresses memory, 1 = ALU result does
//   ir_write    out  1       load instruction register
//   pc_write    out  1       PC <= PC + 1
//   aluop       out  ALUOPW  ALU operation select
//   illegal     out  1       pulse: undefined opcode seen in DECODE
//   instr_done  out  1       pulse on the last cycle of an instruction
//   state       out  3       current state code (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OPW     = 4,
  parameter int ALUOPW  = 3,
  parameter int OP_R    = 0,
  parameter int OP_LW   = 3,
  parameter int OP_SW   = 11,
  parameter int OP_BEQ  = 1,
  parameter int ALU_R   = 4,
  parameter int ALU_ADD = 2,
  parameter int ALU_SUB = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              branch,
  output logic              regdst,
  output logic              alusrc,
  output logic              regwrite,
  output logic              memread,
  output logic              memreg,
  output logic              memwrite,
  output logic              iord,
  output logic              ir_write,
  output logic              pc_write,
  output logic [ALUOPW-1:0] aluop,
  output logic              illegal,
  output logic              instr_done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [OPW-1:0]    C_OP_R    = OPW'(OP_R);
  localparam logic [OPW-1:0]    C_OP_LW   = OPW'(OP_LW);
  localparam logic [OPW-1:0]    C_OP_SW   = OPW'(OP_SW);
  localparam logic [OPW-1:0]    C_OP_BEQ  = OPW'(OP_BEQ);
  localparam logic [ALUOPW-1:0] C_ALU_R   = ALUOPW'(ALU_R);
  localparam logic [ALUOPW-1:0] C_ALU_ADD = ALUOPW'(ALU_ADD);
  localparam logic [ALUOPW-1:0] C_ALU_SUB = ALUOPW'(ALU_SUB);

  state_t         r_state;
  logic [OPW-1:0] r_opcode_q;

  // Legality is judged on the live opcode in DECODE, the same cycle it is latched.
  logic w_legal;
  logic w_q_r, w_q_lw, w_q_sw, w_q_beq;
  logic w_active;

  assign w_legal  = (opcode == C_OP_R) || (opcode == C_OP_LW) ||
                    (opcode == C_OP_SW) || (opcode == C_OP_BEQ);
  assign w_q_r    = (r_opcode_q == C_OP_R);
  assign w_q_lw   = (r_opcode_q == C_OP_LW);
  assign w_q_sw   = (r_opcode_q == C_OP_SW);
  assign w_q_beq  = (r_opcode_q == C_OP_BEQ);
  assign w_active = rst_n && en;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_opcode_q <= '0;
    end else if (en) begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_opcode_q <= opcode;
          r_state    <= w_legal ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          if (w_q_r)                r_state <= S_WB;
          else if (w_q_lw || w_q_sw) r_state <= S_MEM;
          else                      r_state <= S_FETCH;  // BEQ completes here
        end
        S_MEM: begin
          if (mem_ready) r_state <= w_q_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;  // unused codes recover
        end
      endcase
    end
  end

  // The debug state reads 0 during reset, but it still shows the frozen state
  // while en is low.
  assign state = rst_n ? r_state : 3'd0;

  // ---------------------------------------------------------------------------
  // Control strobes, decoded from the current state and latched opcode
  // ---------------------------------------------------------------------------
  always_comb begin
    branch     = 1'b0;
    regdst     = 1'b0;
    alusrc     = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memreg     = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    aluop      = '0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    if (w_active) begin
      case (r_state)
        S_FETCH: begin
          memread  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          illegal    = !w_legal;
          instr_done = !w_legal;  // an illegal opcode retires as a NOP
        end
        S_EXEC: begin
          if (w_q_r) begin
            regdst = 1'b1;
            aluop  = C_ALU_R;
          end else if (w_q_lw || w_q_sw) begin
            alusrc = 1'b1;
            aluop  = C_ALU_ADD;
          end else if (w_q_beq) begin
            branch     = 1'b1;
            aluop      = C_ALU_SUB;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          iord       = 1'b1;
          alusrc     = 1'b1;
          aluop      = C_ALU_ADD;
          memread    = w_q_lw;
          memwrite   = w_q_sw;
          instr_done = w_q_sw && mem_ready;
        end
        S_WB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          regdst     = w_q_r;
          memreg     = w_q_lw;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_control_fsm. Each instruction is modelled as a list
// of phases whose length is the instruction's latency. The expected strobes
// come from the current phase and the instruction class.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       mem_ready = 1'b0;
  logic       branch, regdst, alusrc, regwrite, memread, memreg, memwrite;
  logic       iord, ir_write, pc_write, illegal, instr_done;
  logic [2:0] aluop;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int n_instr = 0;
  int cyc = 0;

  // model: instruction class and position within its phase list
  int m_cls = 5;  // 0 R, 1 LW, 2 SW, 3 BEQ, 4 illegal, 5 not yet decoded
  int m_idx = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .branch(branch), .regdst(regdst), .alusrc(alusrc), .regwrite(regwrite),
    .memread(memread), .memreg(memreg), .memwrite(memwrite), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .aluop(aluop), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [3:0] op);
    case (op)
      4'd0:    return 0;
      4'd3:    return 1;
      4'd11:   return 2;
      4'd1:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cls_len(input int cls);
    case (cls)
      0: return 4;
      1: return 5;
      2: return 4;
      3: return 3;
      4: return 2;
      default: return 99;
    endcase
  endfunction

  // phase = state code: 0 fetch, 1 decode, 2 exec, 3 mem, 4 wb
  function automatic int phase_at(input int cls, input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    if (idx == 2) return 2;
    if (idx == 3) return (cls == 0) ? 4 : 3;
    return 4;
  endfunction

  function automatic logic [17:0] expect_out(input logic r, input logic e,
                                             input logic [3:0] op, input logic mr);
    int ph, cl;
    logic adv;
    logic b, rd, as, rw, mrd, mg, mw, io, irw, pcw, il, dn;
    logic [2:0] ao;
    logic [2:0] st;
    {b, rd, as, rw, mrd, mg, mw, io, irw, pcw, il, dn} = '0;
    ao = 3'd0;
    ph = phase_at(m_cls, m_idx);
    st = r ? 3'(ph) : 3'd0;
    if (r && e) begin
      cl  = (ph == 1) ? classify(op) : m_cls;
      adv = !((ph == 0 || ph == 3) && !mr);
      dn  = (ph != 0) && adv && (m_idx == cls_len(cl) - 1);
      case (ph)
        0: begin mrd = 1'b1; irw = mr; pcw = mr; end
        1: il = (cl == 4);
        2: begin
          if (cl == 0) begin rd = 1'b1; ao = 3'd4; end
          else if (cl == 1 || cl == 2) begin as = 1'b1; ao = 3'd2; end
          else if (cl == 3) begin b = 1'b1; ao = 3'd1; end
        end
        3: begin io = 1'b1; as = 1'b1; ao = 3'd2; mrd = (cl == 1); mw = (cl == 2); end
        4: begin rw = 1'b1; rd = (cl == 0); mg = (cl == 1); end
        default: ;
      endcase
    end
    return {b, rd, as, rw, mrd, mg, mw, io, irw, pcw, ao, il, dn, st};
  endfunction

  task automatic model_update(input logic r, input logic e, input logic [3:0] op,
                              input logic mr);
    int ph;
    if (!r) begin
      m_idx = 0;
      m_cls = 5;
    end else if (e) begin
      ph = phase_at(m_cls, m_idx);
      if (!((ph == 0 || ph == 3) && !mr)) begin
        if (ph == 1) m_cls = classify(op);
        if (m_idx == cls_len(m_cls) - 1) begin
          n_instr++;
          $display("cycle %0d: instr %0d class %0d retired", cyc, n_instr, m_cls);
          m_idx = 0;
          m_cls = 5;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] op,
                      input logic mr, input string tag);
    logic [17:0] exp_v, obs_v;
    @(negedge clk);
    rst_n = r; en = e; opcode = op; mem_ready = mr;
    #1;
    cyc++;
    exp_v = expect_out(r, e, op, mr);
    obs_v = {branch, regdst, alusrc, regwrite, memread, memreg, memwrite, iord,
             ir_write, pc_write, aluop, illegal, instr_done, state};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs_v, exp_v);
    end
    model_update(r, e, op, mr);
  endtask

  initial begin
    int lat_ops [5];
    int lat_exp [5];
    int cnt;
    logic got;
    logic [3:0] op;
    lat_ops = '{0, 3, 11, 1, 7};
    lat_exp = '{4, 5, 4, 3, 2};

    // reset state
    step(0, 1, 4'd0, 0, "reset");
    step(0, 1, 4'd0, 1, "reset");

    // SW aborted by reset in MEM
    step(1, 1, 4'd11, 1, "sw_fetch");
    step(1, 1, 4'd11, 0, "sw_decode");
    step(1, 1, 4'd11, 0, "sw_exec");
    step(1, 1, 4'd11, 0, "sw_mem_wait");
    step(1, 1, 4'd11, 0, "sw_mem_wait");
    step(0, 1, 4'd11, 0, "abort_reset");
    step(0, 1, 4'd11, 0, "abort_reset");
    step(1, 1, 4'd0, 0, "post_reset_fetch");

    // R with mem_ready high
    step(1, 1, 4'd0, 1, "r_fetch");
    step(1, 1, 4'd0, 1, "r_decode");
    step(1, 1, 4'd0, 1, "r_exec");
    step(1, 1, 4'd0, 1, "r_wb");

    // LW with three wait cycles in MEM
    step(1, 1, 4'd3, 1, "lw_fetch");
    step(1, 1, 4'd3, 0, "lw_decode");
    step(1, 1, 4'd3, 0, "lw_exec");
    for (int i = 0; i < 3; i++) step(1, 1, 4'd3, 0, "lw_mem_wait");
    step(1, 1, 4'd3, 1, "lw_mem_done");
    step(1, 1, 4'd3, 0, "lw_wb");

    // SW to completion, BEQ, illegal
    step(1, 1, 4'd11, 1, "sw2_fetch");
    step(1, 1, 4'd11, 1, "sw2_decode");
    step(1, 1, 4'd11, 1, "sw2_exec");
    step(1, 1, 4'd11, 1, "sw2_mem");
    step(1, 1, 4'd1, 1, "beq_fetch");
    step(1, 1, 4'd1, 1, "beq_decode");
    step(1, 1, 4'd1, 1, "beq_exec");
    step(1, 1, 4'd7, 1, "ill_fetch");
    step(1, 1, 4'd7, 1, "ill_decode");

    // en low for 5 cycles while in EXEC of an R instruction
    step(1, 1, 4'd0, 1, "frz_fetch");
    step(1, 1, 4'd0, 1, "frz_decode");
    for (int i = 0; i < 5; i++) step(1, 0, 4'd3, 1, "frz_hold");
    step(1, 1, 4'd3, 1, "frz_exec");
    step(1, 1, 4'd3, 1, "frz_wb");

    // latency per opcode with mem_ready tied high
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 20) begin
        step(1, 1, 4'(lat_ops[k]), 1, "lat_cycle");
        cnt++;
        if (instr_done === 1'b1) got = 1'b1;
      end
      checks++;
      assert (cnt === lat_exp[k]) else begin
        errors++;
        $error("FAIL latency op=%0d observed %0d expected %0d", lat_ops[k], cnt, lat_exp[k]);
      end
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: op = 4'd0;
        1: op = 4'd3;
        2: op = 4'd11;
        3: op = 4'd1;
        4: op = 4'($urandom_range(0, 15));
        default: op = 4'(($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 1) ? 3 : 11));
      endcase
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) != 0), op,
           1'($urandom_range(0, 1)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
